// File: rtl/gelu_lut_pkg.sv
// Shared constants, lane-id sizing helper and the stage-1 tag entry for the GELU LUT arbiter.
package gelu_lut_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 20;

    // Stage-1 tags carry a fixed-width id so one struct serves any lane count up to 256.
    localparam int MAX_ID_WIDTH = 8;

    function automatic int id_width(input int num_lanes);
        if (num_lanes <= 2) begin
            return 1;
        end else begin
            return $clog2(num_lanes);
        end
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [MAX_ID_WIDTH-1:0] id;
    } s1_entry_t;

endpackage

// File: rtl/gelu_lut_arbiter_rr_pick.sv
// Rotating first-one finder: returns the first set bit of elig at or after start, wrapping.
module gelu_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   elig,
    input  logic [IDW-1:0] start,
    output logic           found,
    output logic [IDW-1:0] idx
);

    // Scan N positions from start; the first hit wins and later hits are ignored.
    always_comb begin
        int             pos;
        logic [IDW-1:0] lane;
        logic           take;
        found = 1'b0;
        idx   = {IDW{1'b0}};
        pos   = 0;
        lane  = {IDW{1'b0}};
        take  = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos   = (int'(start) + k >= N) ? int'(start) + k - N : int'(start) + k;
            lane  = IDW'(pos);
            take  = elig[lane] & ~found;
            idx   = take ? lane : idx;
            found = found | take;
        end
    end

endmodule

// File: rtl/gelu_lut_arbiter.sv
// Round-robin sharing of the GELU LUT RAM's two read ports among NUM_REQ lanes,
// with in-flight tracking and a held per-lane response slot.
module gelu_lut_arbiter
    import gelu_lut_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] resp_data,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [ADDR_WIDTH-1:0]         ram_addr_a,
    output logic [ADDR_WIDTH-1:0]         ram_addr_b,
    input  logic [DATA_WIDTH-1:0]         ram_q_a,
    input  logic [DATA_WIDTH-1:0]         ram_q_b,
    output logic                          ram_we_a,
    output logic                          ram_we_b,
    output logic                          busy
);

    localparam int IDW = id_width(NUM_REQ);

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        return (v == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : v + IDW'(1);
    endfunction

    logic [NUM_REQ-1:0]    inflight_s;
    logic [NUM_REQ-1:0]    elig_s;
    logic [NUM_REQ-1:0]    elig_b_s;
    logic [NUM_REQ-1:0]    onehot_a_s;
    logic [NUM_REQ-1:0]    onehot_b_s;
    logic [NUM_REQ-1:0]    grant_s;
    logic                  found_a_s;
    logic                  found_b_s;
    logic                  grant_a_s;
    logic                  grant_b_s;
    logic [IDW-1:0]        pick_a_s;
    logic [IDW-1:0]        pick_b_s;
    logic [IDW-1:0]        start_b_s;
    logic [IDW-1:0]        rr_ptr_r;
    logic [ADDR_WIDTH-1:0] addr_arr_s [NUM_REQ];
    s1_entry_t             s1_a_r;
    s1_entry_t             s1_b_r;

    // A lane whose held result is being consumed this cycle may issue again immediately.
    assign elig_s = req_valid & ~inflight_s & (~resp_valid | resp_ready);

    gelu_rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick_a (
        .elig  (elig_s),
        .start (rr_ptr_r),
        .found (found_a_s),
        .idx   (pick_a_s)
    );

    assign onehot_a_s = NUM_REQ'(1) << pick_a_s;
    assign elig_b_s   = elig_s & ~onehot_a_s;
    assign start_b_s  = wrap_inc(pick_a_s);

    gelu_rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick_b (
        .elig  (elig_b_s),
        .start (start_b_s),
        .found (found_b_s),
        .idx   (pick_b_s)
    );

    assign onehot_b_s = NUM_REQ'(1) << pick_b_s;
    assign grant_a_s  = found_a_s & ~rst;
    assign grant_b_s  = found_b_s & found_a_s & ~rst;
    assign grant_s    = ({NUM_REQ{grant_a_s}} & onehot_a_s) | ({NUM_REQ{grant_b_s}} & onehot_b_s);
    assign req_ready  = grant_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr_s[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    assign ram_addr_a = grant_a_s ? addr_arr_s[pick_a_s] : {ADDR_WIDTH{1'b0}};
    assign ram_addr_b = grant_b_s ? addr_arr_s[pick_b_s] : {ADDR_WIDTH{1'b0}};
    assign ram_we_a   = 1'b0;
    assign ram_we_b   = 1'b0;
    assign busy       = (|inflight_s) | (|resp_valid);

    // Stage-1 port tags track the RAM's one-cycle read; the pointer moves past the last grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= {IDW{1'b0}};
            s1_a_r   <= '{valid: 1'b0, id: {MAX_ID_WIDTH{1'b0}}};
            s1_b_r   <= '{valid: 1'b0, id: {MAX_ID_WIDTH{1'b0}}};
        end else begin
            s1_a_r.valid <= grant_a_s;
            s1_a_r.id    <= MAX_ID_WIDTH'(pick_a_s);
            s1_b_r.valid <= grant_b_s;
            s1_b_r.id    <= MAX_ID_WIDTH'(pick_b_s);
            if (grant_b_s) begin
                rr_ptr_r <= wrap_inc(pick_b_s);
            end else if (grant_a_s) begin
                rr_ptr_r <= wrap_inc(pick_a_s);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        logic                  wr_a_s;
        logic                  wr_b_s;
        logic                  vld_r;
        logic                  infl_r;
        logic [DATA_WIDTH-1:0] data_r;

        assign wr_a_s = s1_a_r.valid && (s1_a_r.id == MAX_ID_WIDTH'(g));
        assign wr_b_s = s1_b_r.valid && (s1_b_r.id == MAX_ID_WIDTH'(g));

        // Response slot: a returning read always lands, otherwise the held value waits for ready.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_r  <= 1'b0;
                infl_r <= 1'b0;
                data_r <= {DATA_WIDTH{1'b0}};
            end else begin
                if (wr_a_s) begin
                    vld_r  <= 1'b1;
                    data_r <= ram_q_a;
                end else if (wr_b_s) begin
                    vld_r  <= 1'b1;
                    data_r <= ram_q_b;
                end else if (resp_ready[g]) begin
                    vld_r  <= 1'b0;
                end else begin
                    vld_r  <= vld_r;
                end
                if (grant_s[g]) begin
                    infl_r <= 1'b1;
                end else if (wr_a_s || wr_b_s) begin
                    infl_r <= 1'b0;
                end else begin
                    infl_r <= infl_r;
                end
            end
        end

        assign resp_valid[g]                         = vld_r;
        assign inflight_s[g]                         = infl_r;
        assign resp_data[g*DATA_WIDTH +: DATA_WIDTH] = data_r;
    end

endmodule

// File: tb/tb_gelu_lut_arbiter.sv
// Directed and soak checks of gelu_lut_arbiter against a behavioural 1-cycle LUT RAM.
module tb_gelu_lut_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [N*DW-1:0] resp_data;
    logic [N-1:0]    resp_ready;
    logic [AW-1:0]   ram_addr_a;
    logic [AW-1:0]   ram_addr_b;
    logic [DW-1:0]   ram_q_a;
    logic [DW-1:0]   ram_q_b;
    logic            ram_we_a;
    logic            ram_we_b;
    logic            busy;

    logic [DW-1:0]   mem [16];
    logic [DW-1:0]   sbq [N][$];
    int              grant_cnt [N];
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    gelu_lut_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_q_a    (ram_q_a),
        .ram_q_b    (ram_q_b),
        .ram_we_a   (ram_we_a),
        .ram_we_b   (ram_we_b),
        .busy       (busy)
    );

    always @(posedge clk) begin
        ram_q_a <= mem[ram_addr_a];
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int lane);
        return resp_data[lane*DW +: DW];
    endfunction

    task automatic set_addr(input int lane, input logic [AW-1:0] a);
        req_addr[lane*AW +: AW] = a;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        req_valid  = 4'b0000;
        resp_ready = 4'b0000;
        next_cycle();
        next_cycle();
        rst        = 1'b0;
        resp_ready = 4'b1111;
    endtask

    task automatic idle(input int n);
        req_valid  = 4'b0000;
        resp_ready = 4'b1111;
        for (int k = 0; k < n; k++) next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 20'(32'h10000 + i * 32'h01357);
        mem[5]     = 20'h0ABCD;
        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_addr   = 16'h0000;
        resp_ready = 4'b0000;

        // Reset state, with requests raised to show the grant is gated.
        next_cycle();
        req_valid = 4'b1111;
        settle();
        check_eq("rst_req_ready", req_ready, 4'b0000);
        check_eq("rst_resp_valid", resp_valid, 4'b0000);
        check_eq("rst_resp_data", resp_data, 80'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_addr_a", ram_addr_a, 4'h0);
        check_eq("rst_addr_b", ram_addr_b, 4'h0);
        check_eq("rst_we", {ram_we_a, ram_we_b}, 2'b00);
        next_cycle();
        rst        = 1'b0;
        req_valid  = 4'b0000;
        resp_ready = 4'b1111;

        // Single lane.
        set_addr(0, 4'd5);
        req_valid = 4'b0001;
        settle();
        check_eq("single_ready", req_ready, 4'b0001);
        check_eq("single_addr_a", ram_addr_a, 4'd5);
        check_eq("single_addr_b", ram_addr_b, 4'd0);
        next_cycle();
        req_valid = 4'b0000;
        settle();
        check_eq("single_t1_valid", resp_valid, 4'b0000);
        check_eq("single_t1_busy", busy, 1'b1);
        next_cycle();
        settle();
        check_eq("single_t2_valid", resp_valid, 4'b0001);
        check_eq("single_t2_data", rd(0), 20'h0ABCD);
        next_cycle();
        settle();
        check_eq("single_consumed", resp_valid, 4'b0000);
        check_eq("single_idle_busy", busy, 1'b0);

        // Dual issue, then the pointer must sit at 3.
        apply_reset();
        set_addr(1, 4'd3);
        set_addr(2, 4'd9);
        req_valid = 4'b0110;
        settle();
        check_eq("dual_ready", req_ready, 4'b0110);
        check_eq("dual_addr_a", ram_addr_a, 4'd3);
        check_eq("dual_addr_b", ram_addr_b, 4'd9);
        next_cycle();
        req_valid = 4'b0000;
        next_cycle();
        settle();
        check_eq("dual_valid", resp_valid, 4'b0110);
        check_eq("dual_data1", rd(1), mem[3]);
        check_eq("dual_data2", rd(2), mem[9]);
        next_cycle();
        set_addr(0, 4'd1);
        set_addr(1, 4'd2);
        set_addr(2, 4'd4);
        set_addr(3, 4'd6);
        req_valid = 4'b1111;
        settle();
        check_eq("dual_rr_ready", req_ready, 4'b1001);
        check_eq("dual_rr_addr_a", ram_addr_a, 4'd6);
        check_eq("dual_rr_addr_b", ram_addr_b, 4'd1);
        idle(4);

        // Round-robin fairness with all lanes continuously requesting.
        apply_reset();
        for (int i = 0; i < N; i++) begin
            set_addr(i, AW'(i + 4));
            grant_cnt[i] = 0;
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 100; c++) begin
            settle();
            check_eq("fair_grant", req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) grant_cnt[i]++;
                if (resp_valid[i]) check_eq("fair_data", rd(i), mem[i + 4]);
            end
            next_cycle();
        end
        for (int i = 0; i < N; i++) check_eq("fair_count", grant_cnt[i], 50);
        idle(4);

        // Back-pressure on lane 2.
        apply_reset();
        resp_ready = 4'b1011;
        set_addr(2, 4'd7);
        req_valid = 4'b0100;
        settle();
        check_eq("bp_grant", req_ready, 4'b0100);
        check_eq("bp_addr_a", ram_addr_a, 4'd7);
        next_cycle();
        set_addr(2, 4'd8);
        settle();
        check_eq("bp_inflight_ready", req_ready, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            settle();
            check_eq("bp_hold_ready", req_ready, 4'b0000);
            check_eq("bp_hold_valid", resp_valid[2], 1'b1);
            check_eq("bp_hold_data", rd(2), mem[7]);
        end
        next_cycle();
        resp_ready = 4'b1111;
        settle();
        check_eq("bp_regrant", req_ready, 4'b0100);
        check_eq("bp_regrant_addr", ram_addr_a, 4'd8);
        next_cycle();
        req_valid  = 4'b0000;
        resp_ready = 4'b1011;
        settle();
        check_eq("bp_drained", resp_valid[2], 1'b0);
        next_cycle();
        settle();
        check_eq("bp_new_valid", resp_valid[2], 1'b1);
        check_eq("bp_new_data", rd(2), mem[8]);
        idle(4);

        // Reset while lanes 0 and 3 are in flight.
        apply_reset();
        set_addr(0, 4'd2);
        set_addr(3, 4'd11);
        req_valid = 4'b1001;
        settle();
        check_eq("rstmid_grant", req_ready, 4'b1001);
        next_cycle();
        rst       = 1'b1;
        req_valid = 4'b0000;
        settle();
        check_eq("rstmid_addr_a", ram_addr_a, 4'd0);
        next_cycle();
        rst = 1'b0;
        settle();
        check_eq("rstmid_busy", busy, 1'b0);
        check_eq("rstmid_valid", resp_valid, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            settle();
            check_eq("rstmid_no_resp", resp_valid, 4'b0000);
        end

        // Random soak against per-lane scoreboard queues.
        apply_reset();
        for (int cyc = 0; cyc < 10000 + 8; cyc++) begin
            if (cyc < 10000) begin
                req_valid  = 4'($urandom_range(0, 15));
                req_addr   = 16'($urandom);
                resp_ready = 4'($urandom_range(0, 15));
            end else begin
                req_valid  = 4'b0000;
                resp_ready = 4'b1111;
            end
            settle();
            check_eq("soak_ready_subset", req_ready & ~req_valid, 4'b0000);
            check_eq("soak_two_ports", $countones(req_ready) <= 2, 1'b1);
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    check_eq("soak_depth", sbq[i].size(), 1);
                    if (sbq[i].size() > 0) check_eq("soak_data", rd(i), sbq[i].pop_front());
                end
                if (req_valid[i] && req_ready[i]) sbq[i].push_back(mem[req_addr[i*AW +: AW]]);
            end
            next_cycle();
        end
        settle();
        for (int i = 0; i < N; i++) check_eq("soak_drained", sbq[i].size(), 0);
        check_eq("soak_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
